branch_redirect_ctrl: RTL

Sequencing controller for the MEM-stage branch decision in the 5-stage pipeline. It qualifies the MEM-stage branch and zero flags and registers the taken decision and target. It drives the PC-source select and target for one cycle, then squashes the wrong-path instructions by pulsing the pipeline-register flush lines for a programmable number of cycles. The IF-stage PC mux and the IF/ID, ID/EX and EX/MEM registers are driven from this block.

---
 rtl/branch_redirect_if.sv | 31 +++
 rtl/branch_redirect_ctrl.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/branch_redirect_if.sv
// MEM-stage branch bundle between the pipeline and branch_redirect_ctrl.
// The master side is the pipeline and the slave side is the redirect controller.
interface branch_redirect_if #(
  parameter int ADDR_W = 32
);
  // Qualification rule: a branch is presented when mem_valid & mem_branch are
  // high. It is consumed only on a rising edge where stall_in is low and the
  // controller is idle. There is no ready back-pressure: a branch presented
  // while the controller is busy is wrong-path and is simply dropped.
  logic              mem_valid;
  logic              mem_branch;
  logic              mem_zero;
  logic [ADDR_W-1:0] mem_target;
  logic              stall_in;

  logic              pcsrc;
  logic [ADDR_W-1:0] pc_target;
  logic              flush_ifid;
  logic              flush_idex;
  logic              flush_exmem;

  modport master (
    output mem_valid, mem_branch, mem_zero, mem_target, stall_in,
    input  pcsrc, pc_target, flush_ifid, flush_idex, flush_exmem
  );

  modport slave (
    input  mem_valid, mem_branch, mem_zero, mem_target, stall_in,
    output pcsrc, pc_target, flush_ifid, flush_idex, flush_exmem
  );
endinterface

// File: rtl/branch_redirect_ctrl.sv
// MEM-stage branch redirect sequencer: PC redirect followed by wrong-path squash.
// Optional branch statistics counters are enabled by defining BRANCH_STATS_EN.
module branch_redirect_ctrl #(
  parameter int ADDR_W        = 32,
  parameter int SQUASH_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  branch_redirect_if.slave    bus,
  output logic                busy,
  output logic [31:0]         branch_cnt,
  output logic [31:0]         taken_cnt,
  output logic [1:0]          state_dbg
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    SQUASH   = 2'd2
  } state_t;

  localparam logic [2:0] SQUASH_INIT = 3'(SQUASH_CYCLES);

  state_t            state;
  state_t            state_next;
  logic [2:0]        cnt;
  logic [2:0]        cnt_next;
  logic              capture;
  logic              is_branch;
  logic              take;

  logic              pcsrc_q;
  logic              flush_ifid_q;
  logic              flush_idex_q;
  logic              flush_exmem_q;
  logic              busy_q;
  logic [ADDR_W-1:0] pc_target_q;

  assign is_branch = bus.mem_valid & bus.mem_branch & ~bus.stall_in;
  assign take      = is_branch & bus.mem_zero;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (take) begin
          capture    = 1'b1;
          state_next = REDIRECT;
        end
      end
      REDIRECT: begin
        if (!bus.stall_in) begin
          cnt_next   = SQUASH_INIT;
          state_next = (SQUASH_CYCLES == 0) ? IDLE : SQUASH;
        end
      end
      SQUASH: begin
        if (!bus.stall_in) begin
          cnt_next = cnt - 3'd1;
          if (cnt <= 3'd1) begin
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 3'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Outputs are flopped from the next state so they align with the state
  // register and carry no combinational path from the inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcsrc_q       <= 1'b0;
      flush_ifid_q  <= 1'b0;
      flush_idex_q  <= 1'b0;
      flush_exmem_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      pcsrc_q       <= (state_next == REDIRECT);
      flush_ifid_q  <= (state_next != IDLE);
      flush_idex_q  <= (state_next == REDIRECT);
      flush_exmem_q <= (state_next == REDIRECT);
      busy_q        <= (state_next != IDLE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_target_q <= '0;
    end else if (capture) begin
      pc_target_q <= bus.mem_target;
    end
  end

`ifdef BRANCH_STATS_EN
  logic [31:0] branch_cnt_q;
  logic [31:0] taken_cnt_q;

  // Only branches seen while idle are architectural; busy-time ones are wrong-path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_cnt_q <= 32'd0;
      taken_cnt_q  <= 32'd0;
    end else begin
      if ((state == IDLE) && is_branch) begin
        branch_cnt_q <= branch_cnt_q + 32'd1;
      end
      if (capture) begin
        taken_cnt_q <= taken_cnt_q + 32'd1;
      end
    end
  end

  assign branch_cnt = branch_cnt_q;
  assign taken_cnt  = taken_cnt_q;
`else
  assign branch_cnt = 32'd0;
  assign taken_cnt  = 32'd0;
`endif

  assign bus.pcsrc       = pcsrc_q;
  assign bus.pc_target   = pc_target_q;
  assign bus.flush_ifid  = flush_ifid_q;
  assign bus.flush_idex  = flush_idex_q;
  assign bus.flush_exmem = flush_exmem_q;
  assign busy            = busy_q;
  assign state_dbg       = state;

endmodule
